// File: rtl/data_mem_responder.sv
// Load/store data memory with a fixed-latency, in-order response pipeline.
// Requests are accepted every cycle (no backpressure). Stores commit and loads
// sample the array on the accepting edge. The response then walks a LATENCY-deep
// shift pipeline and emerges exactly LATENCY cycles later.
package data_mem_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memReqStruct;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memRespStruct;
endpackage

module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 256,
  parameter int LATENCY         = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  memReqStruct  req,
  input  logic [3:0]   req_robNum,
  input  logic         flush,
  output memRespStruct resp,
  output logic [3:0]   resp_robNum,
  output logic         resp_err,
  output logic [2:0]   inflight
);
  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

  // Payload carried alongside each valid bit; all-zero whenever the stage is empty.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } stage_t;

  logic [31:0]      mem [MEM_DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             oor, illegal, accept, do_store, do_load;
  logic             unused_addr_lsb;

  // vld_pipe[0] is the request being accepted this edge; [LATENCY] is the response.
  logic [LATENCY:0] vld_pipe;
  logic [LATENCY:1] vld_q;
  stage_t           pay_in;
  stage_t           pay_q [1:LATENCY];

  // Byte offset within a word is irrelevant to a word-wide memory.
  assign unused_addr_lsb = ^req.addr[1:0];

  assign idx      = req.addr[IDX_W+1:2];
  assign oor      = |req.addr[31:IDX_W+2];
  assign illegal  = req.MemRead & req.MemWrite;
  assign accept   = req.valid & ~flush;
  assign do_store = accept & req.MemWrite & ~req.MemRead & ~oor;
  assign do_load  = accept & req.MemRead & ~req.MemWrite & ~oor;
  assign vld_pipe = {vld_q, accept};

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_store) mem[idx] <= req.wr_data;
  end

  // Build the stage-1 payload; rejected cycles inject an all-zero bubble.
  always_comb begin
    pay_in = '0;
    if (accept) begin
      pay_in.rd  = req.MemRead;
      pay_in.wr  = req.MemWrite;
      pay_in.tag = req_robNum;
      pay_in.err = oor | illegal;
      if (do_load) pay_in.data = mem[idx];
    end
  end

  // Response shift pipeline; flush empties every stage including its payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 1; s <= LATENCY; s++) pay_q[s] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      for (int s = 1; s <= LATENCY; s++) pay_q[s] <= '0;
    end else begin
      vld_q    <= vld_pipe[LATENCY-1:0];
      pay_q[1] <= pay_in;
      for (int s = 2; s <= LATENCY; s++) pay_q[s] <= pay_q[s-1];
    end
  end

  // In-flight count is the number of occupied pipeline stages.
  always_comb begin
    inflight = '0;
    for (int s = 1; s <= LATENCY; s++) inflight = inflight + 3'(vld_q[s]);
  end

  assign resp.valid    = vld_q[LATENCY];
  assign resp.rd_data  = pay_q[LATENCY].data;
  assign resp.MemRead  = pay_q[LATENCY].rd;
  assign resp.MemWrite = pay_q[LATENCY].wr;
  assign resp_robNum   = pay_q[LATENCY].tag;
  assign resp_err      = pay_q[LATENCY].err;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH_WORDS, default 256, meaning the number of 32-bit words stored (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response (legal range 1..4).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset; asynchronous, active-low.
REQ-005 SHALL have port req  input  memReqStruct  meaning the load/store request (addr, wr_data, MemWrite, MemRead, valid).
REQ-006 SHALL have port req_robNum  input  4  meaning the ROB tag travelling with req.
REQ-007 SHALL have port flush  input  1  meaning to discard all in-flight responses and the current request.
REQ-008 SHALL have port resp  output  memRespStruct  meaning the response (rd_data, MemWrite, MemRead, valid).
REQ-009 SHALL have port resp_robNum  output  4  meaning the ROB tag of resp.
REQ-010 SHALL have port resp_err  output  1  meaning the response is for an out-of-range or illegal request.
REQ-011 SHALL have port inflight  output  3  meaning the count of accepted requests not yet responded.

Function
REQ-012 SHALL accept a request on every rising edge where req.valid=1 and flush=0; no backpressure, one request per cycle.
REQ-013 SHALL form the word index as addr[log2(MEM_DEPTH_WORDS)+1:2]; addr[1:0] ignored.
REQ-014 SHALL treat a request as out-of-range when any addr bit above the index is 1: no write, rd_data=0, resp_err=1.
REQ-015 SHALL commit a store (MemWrite=1, MemRead=0) to the array on the accepting edge.
REQ-016 SHALL sample load data (MemRead=1, MemWrite=0) from the array on the accepting edge, so a load accepted the cycle after a store to the same word returns the new data.
REQ-017 SHALL treat MemRead=1 with MemWrite=1 as illegal: no write, rd_data=0, resp_err=1.
REQ-018 SHALL treat valid=1 with MemRead=MemWrite=0 as a no-op that still produces a response with rd_data=0 and resp_err=0.
REQ-019 SHALL assert resp.valid for exactly one cycle, exactly LATENCY cycles after acceptance, in acceptance order.
REQ-020 SHALL echo MemRead, MemWrite and req_robNum of the request on the response; rd_data=0 for store responses.
REQ-021 SHALL drive resp.rd_data, resp_err, resp_robNum and the resp flags to 0 whenever resp.valid=0.
REQ-022 SHALL implement the response path as a LATENCY-stage shift pipeline of {valid, flags, tag, data, err}.
REQ-023 SHALL, when flush=1 on an edge, clear every pipeline valid bit and drop the current request (no write); stores committed earlier are kept.
REQ-024 SHALL report inflight as the number of valid pipeline stages: +1 on accept, -1 on response, unchanged when both happen, 0 after flush.

Reset
REQ-025 SHALL, while rst_n=0, hold all pipeline valids, resp fields, resp_robNum, resp_err and inflight at 0.
REQ-026 SHALL leave array contents unchanged by reset; the contents after power-up are undefined.
REQ-027 SHALL drop any request in flight when reset asserts mid-operation; no response is produced for it.
REQ-028 SHALL accept a request on the first rising edge with rst_n=1.

Verification
REQ-029 Store addr=0x10 data=0xDEADBEEF at cycle 0, load addr=0x10 at cycle 1 -> cycle 2: store response rd_data=0; cycle 3: load response rd_data=0xDEADBEEF (LATENCY=2).
REQ-030 Back-to-back loads on 4 cycles with tags 1,2,3,4 -> 4 consecutive resp.valid cycles, tags 1,2,3,4 in order; inflight reaches 2 and stays 2 until the stream ends.
REQ-031 Store addr=0x400 with depth 256 -> resp_err=1 and no write; a later load of addr=0x0 returns the prior value.
REQ-032 Load accepted in cycle 0, flush=1 in cycle 1 together with a store -> no response in cycle 2; the store is not written; inflight=0.
REQ-033 MemRead=MemWrite=1 -> response with resp_err=1 and rd_data=0; the target word is unchanged.
REQ-034 rst_n pulsed low mid-stream -> resp.valid=0 and inflight=0 immediately (asynchronous); stores committed before reset can still be read back.
